video_timing_gen: RTL and testbench

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

---
 rtl/video_timing_gen.sv | 163 ++++++++++++++++
 tb/tb_video_timing_gen.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
// video_timing_gen : pixel clock-enable divider and raster timing generator
// Rev 1.0
// ============================================================================
module video_timing_gen #(
    parameter int CE_DIV   = 4,
    parameter int H_TOTAL  = 384,
    parameter int H_ACTIVE = 320,
    parameter int HS_START = 336,
    parameter int HS_WIDTH = 32,
    parameter int V_TOTAL  = 264,
    parameter int V_ACTIVE = 240,
    parameter int VS_START = 244,
    parameter int VS_WIDTH = 3
) (
    input  logic              clk_video,
    input  logic              reset,
    input  logic signed [3:0] h_adj,
    input  logic signed [2:0] v_adj,
    output logic              ce_pix,
    output logic [8:0]        hcount,
    output logic [8:0]        vcount,
    output logic              HBlank,
    output logic              VBlank,
    output logic              HSync,
    output logic              VSync,
    output logic              frame_start,
    output logic              line_start
);

    localparam int DIV_W = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;

    localparam logic [DIV_W-1:0] c_div_last = DIV_W'(CE_DIV - 1);
    localparam logic [8:0]       c_h_last   = 9'(H_TOTAL - 1);
    localparam logic [8:0]       c_v_last   = 9'(V_TOTAL - 1);
    localparam logic [8:0]       c_h_act    = 9'(H_ACTIVE);
    localparam logic [8:0]       c_v_act    = 9'(V_ACTIVE);

    localparam logic signed [10:0] c_hs_base = 11'(HS_START);
    localparam logic signed [10:0] c_hs_lo   = 11'(H_ACTIVE);
    localparam logic signed [10:0] c_hs_hi   = 11'(H_TOTAL - HS_WIDTH);
    localparam logic signed [10:0] c_hs_w    = 11'(HS_WIDTH);
    localparam logic signed [10:0] c_vs_base = 11'(VS_START);
    localparam logic signed [10:0] c_vs_lo   = 11'(V_ACTIVE);
    localparam logic signed [10:0] c_vs_hi   = 11'(V_TOTAL - VS_WIDTH);
    localparam logic signed [10:0] c_vs_w    = 11'(VS_WIDTH);

    if (CE_DIV < 2 || CE_DIV > 16) begin : g_bad_ce_div
        $error("video_timing_gen: CE_DIV must be in 2..16");
    end
    if (H_ACTIVE >= H_TOTAL) begin : g_bad_h_active
        $error("video_timing_gen: H_ACTIVE must be below H_TOTAL");
    end
    if (V_ACTIVE >= V_TOTAL) begin : g_bad_v_active
        $error("video_timing_gen: V_ACTIVE must be below V_TOTAL");
    end
    if (H_TOTAL > 512 || V_TOTAL > 512) begin : g_bad_total
        $error("video_timing_gen: H_TOTAL and V_TOTAL must not exceed 512");
    end

    logic [DIV_W-1:0]  div_q, div_d;
    logic [8:0]        hcount_q, hcount_d, vcount_q, vcount_d;
    logic              ce_pix_q, ce_pix_d;
    logic              hblank_q, hblank_d, vblank_q, vblank_d;
    logic              hsync_q, hsync_d, vsync_q, vsync_d;
    logic              frame_start_q, frame_start_d, line_start_q, line_start_d;
    logic signed [3:0] h_shadow_q, h_shadow_d;
    logic signed [2:0] v_shadow_q, v_shadow_d;

    logic              pix_tick, h_wrap, v_wrap;
    logic [8:0]        h_next, v_next;
    logic signed [10:0] h_next_s, v_next_s;
    logic signed [10:0] hs_raw, vs_raw, hs0, vs0, hs_end, vs_end;

    assign pix_tick = (div_q == c_div_last);
    assign h_wrap   = (hcount_q == c_h_last);
    assign v_wrap   = (vcount_q == c_v_last);
    assign h_next   = h_wrap ? 9'd0 : hcount_q + 9'd1;
    assign v_next   = !h_wrap ? vcount_q : (v_wrap ? 9'd0 : vcount_q + 9'd1);
    assign h_next_s = signed'({2'b00, h_next});
    assign v_next_s = signed'({2'b00, v_next});

    // Sync starts are the nominal position plus the frame-latched shift, clamped into blanking
    assign hs_raw = c_hs_base + signed'({{7{h_shadow_q[3]}}, h_shadow_q});
    assign vs_raw = c_vs_base + signed'({{8{v_shadow_q[2]}}, v_shadow_q});
    assign hs0    = (hs_raw < c_hs_lo) ? c_hs_lo : ((hs_raw > c_hs_hi) ? c_hs_hi : hs_raw);
    assign vs0    = (vs_raw < c_vs_lo) ? c_vs_lo : ((vs_raw > c_vs_hi) ? c_vs_hi : vs_raw);
    assign hs_end = hs0 + c_hs_w;
    assign vs_end = vs0 + c_vs_w;

    always_comb begin
        div_d         = pix_tick ? '0 : div_q + 1'b1;
        hcount_d      = hcount_q;
        vcount_d      = vcount_q;
        hblank_d      = hblank_q;
        vblank_d      = vblank_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        h_shadow_d    = h_shadow_q;
        v_shadow_d    = v_shadow_q;
        ce_pix_d      = pix_tick;
        line_start_d  = pix_tick && h_wrap;
        frame_start_d = pix_tick && h_wrap && v_wrap;
        if (pix_tick) begin
            hcount_d = h_next;
            vcount_d = v_next;
            hblank_d = (h_next >= c_h_act);
            vblank_d = (v_next >= c_v_act);
            hsync_d  = (h_next_s >= hs0) && (h_next_s < hs_end);
            // VSync only moves on the HSync leading pixel so both edges line up
            if (h_next_s == hs0) begin
                vsync_d = (v_next_s >= vs0) && (v_next_s < vs_end);
            end
            if (h_wrap && v_wrap) begin
                h_shadow_d = h_adj;
                v_shadow_d = v_adj;
            end
        end
    end

    always_ff @(posedge clk_video) begin
        if (reset) begin
            div_q         <= '0;
            hcount_q      <= c_h_last;
            vcount_q      <= c_v_last;
            ce_pix_q      <= 1'b0;
            hblank_q      <= 1'b1;
            vblank_q      <= 1'b1;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            frame_start_q <= 1'b0;
            line_start_q  <= 1'b0;
            h_shadow_q    <= h_adj;
            v_shadow_q    <= v_adj;
        end else begin
            div_q         <= div_d;
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            ce_pix_q      <= ce_pix_d;
            hblank_q      <= hblank_d;
            vblank_q      <= vblank_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
            line_start_q  <= line_start_d;
            h_shadow_q    <= h_shadow_d;
            v_shadow_q    <= v_shadow_d;
        end
    end

    assign ce_pix      = ce_pix_q;
    assign hcount      = hcount_q;
    assign vcount      = vcount_q;
    assign HBlank      = hblank_q;
    assign VBlank      = vblank_q;
    assign HSync       = hsync_q;
    assign VSync       = vsync_q;
    assign frame_start = frame_start_q;
    assign line_start  = line_start_q;

endmodule
`default_nettype wire

// File: tb/tb_video_timing_gen.sv
`default_nettype none
// ============================================================================
// tb_video_timing_gen : scoreboard bench for video_timing_gen on a reduced raster
// Rev 1.0
// ============================================================================
module tb_video_timing_gen;

    localparam int CE_DIV   = 4;
    localparam int H_TOTAL  = 64;
    localparam int H_ACTIVE = 40;
    localparam int HS_START = 52;
    localparam int HS_WIDTH = 8;
    localparam int V_TOTAL  = 20;
    localparam int V_ACTIVE = 12;
    localparam int VS_START = 13;
    localparam int VS_WIDTH = 2;

    typedef struct {
        bit       ce;
        int       h;
        int       v;
        bit [5:0] flags;   // HBlank, VBlank, HSync, VSync, frame_start, line_start
    } exp_t;

    logic              clk_video = 1'b0;
    logic              reset     = 1'b1;
    logic signed [3:0] h_adj     = '0;
    logic signed [2:0] v_adj     = '0;
    logic              ce_pix, HBlank, VBlank, HSync, VSync, frame_start, line_start;
    logic [8:0]        hcount, vcount;

    video_timing_gen #(
        .CE_DIV(CE_DIV), .H_TOTAL(H_TOTAL), .H_ACTIVE(H_ACTIVE),
        .HS_START(HS_START), .HS_WIDTH(HS_WIDTH), .V_TOTAL(V_TOTAL),
        .V_ACTIVE(V_ACTIVE), .VS_START(VS_START), .VS_WIDTH(VS_WIDTH)
    ) dut (
        .clk_video(clk_video), .reset(reset), .h_adj(h_adj), .v_adj(v_adj),
        .ce_pix(ce_pix), .hcount(hcount), .vcount(vcount),
        .HBlank(HBlank), .VBlank(VBlank), .HSync(HSync), .VSync(VSync),
        .frame_start(frame_start), .line_start(line_start)
    );

    always #5 clk_video = ~clk_video;

    int  n_vec = 0;
    int  n_bad = 0;
    exp_t sb_q[$];

    bit              rst_v = 1'b1;
    logic signed [3:0] ha_v = '0;
    logic signed [2:0] va_v = '0;

    int  m_div, m_h, m_v, m_hsh, m_vsh;
    bit  e_ce, e_hb, e_vb, e_hs, e_vs, e_fs, e_ls;
    int  act_cnt = 0, last_act = 0;
    bit  hs_last = 0, vs_last = 0, hs_rose, hs_fell, vs_rose, vs_fell;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int clampi(input int x, input int lo, input int hi);
        return (x < lo) ? lo : ((x > hi) ? hi : x);
    endfunction

    task automatic model_step(output exp_t e);
        int hs0, vs0;
        if (rst_v) begin
            m_div = 0; m_h = H_TOTAL - 1; m_v = V_TOTAL - 1;
            e_ce = 0; e_hb = 1; e_vb = 1; e_hs = 0; e_vs = 0; e_fs = 0; e_ls = 0;
            m_hsh = ha_v; m_vsh = va_v;
        end else begin
            e_ce = 0; e_fs = 0; e_ls = 0;
            if (m_div == CE_DIV - 1) begin
                m_div = 0;
                e_ce  = 1;
                hs0 = clampi(HS_START + m_hsh, H_ACTIVE, H_TOTAL - HS_WIDTH);
                vs0 = clampi(VS_START + m_vsh, V_ACTIVE, V_TOTAL - VS_WIDTH);
                m_h = (m_h + 1) % H_TOTAL;
                if (m_h == 0) begin
                    e_ls = 1;
                    m_v  = (m_v + 1) % V_TOTAL;
                    if (m_v == 0) begin
                        e_fs = 1; m_hsh = ha_v; m_vsh = va_v;
                    end
                end
                e_hb = (m_h >= H_ACTIVE);
                e_vb = (m_v >= V_ACTIVE);
                e_hs = (m_h >= hs0) && (m_h < hs0 + HS_WIDTH);
                if (m_h == hs0) e_vs = (m_v >= vs0) && (m_v < vs0 + VS_WIDTH);
            end else begin
                m_div++;
            end
        end
        e.ce = e_ce; e.h = m_h; e.v = m_v;
        e.flags = {e_hb, e_vb, e_hs, e_vs, e_fs, e_ls};
    endtask

    // One clock: drive on the falling edge, predict, then compare just after the rising edge
    task automatic cyc();
        exp_t e, g;
        @(negedge clk_video);
        reset = rst_v; h_adj = ha_v; v_adj = va_v;
        model_step(e);
        sb_q.push_back(e);
        @(posedge clk_video);
        #1;
        g = sb_q.pop_front();
        chk("ce_pix", ce_pix, g.ce);
        chk("hcount", hcount, g.h);
        chk("vcount", vcount, g.v);
        chk("flags", {HBlank, VBlank, HSync, VSync, frame_start, line_start}, g.flags);
        if (frame_start) begin
            last_act = act_cnt; act_cnt = 0;
        end
        if (ce_pix && !HBlank && !VBlank) act_cnt++;
        hs_rose = HSync && !hs_last; hs_fell = !HSync && hs_last;
        vs_rose = VSync && !vs_last; vs_fell = !VSync && vs_last;
        hs_last = HSync; vs_last = VSync;
    endtask

    function automatic bit ev_hit(input int kind);
        case (kind)
            0: return frame_start;
            1: return hs_rose;
            2: return hs_fell;
            3: return vs_rose;
            default: return vs_fell;
        endcase
    endfunction

    // kind: 0 frame_start, 1 HSync rise, 2 HSync fall, 3 VSync rise, 4 VSync fall
    task automatic wait_ev(input int kind, input int bound, output int n);
        n = 0;
        do begin
            cyc(); n++;
        end while (!ev_hit(kind) && n < bound);
        if (!ev_hit(kind)) chk("timeout", ev_hit(kind), 1);
    endtask

    task automatic run_until_v(input int line, input int bound);
        int n = 0;
        do begin
            cyc(); n++;
        end while (!(line_start && vcount == line) && n < bound);
        if (!(line_start && vcount == line)) chk("timeout_v", vcount, line);
    endtask

    localparam int FRAME_CLKS = H_TOTAL * V_TOTAL * CE_DIV;

    initial begin
        int n;
        rst_v = 1; ha_v = 0; va_v = 0;
        repeat (3) cyc();
        chk("rst_hcount", hcount, H_TOTAL - 1);
        chk("rst_vcount", vcount, V_TOTAL - 1);
        chk("rst_flags", {ce_pix, HBlank, VBlank, HSync, VSync, frame_start, line_start}, 7'b0110000);

        // Defaults: first ce_pix on the 4th clock, sync positions, frame period
        rst_v = 0;
        wait_ev(0, 20, n);
        chk("first_fs_clk", n, CE_DIV);
        chk("first_ls", line_start, 1);
        wait_ev(1, 400, n);
        chk("hs_rise_h", hcount, 52);
        wait_ev(2, 400, n);
        chk("hs_fall_h", hcount, 60);
        wait_ev(3, 2 * FRAME_CLKS, n);
        chk("vs_rise_h", hcount, 52);
        chk("vs_rise_v", vcount, 13);
        wait_ev(4, 2 * FRAME_CLKS, n);
        chk("vs_fall_v", vcount, 15);
        wait_ev(0, 2 * FRAME_CLKS, n);
        wait_ev(0, 2 * FRAME_CLKS, n);
        chk("fs_period", n, FRAME_CLKS);
        chk("active_px", last_act, H_ACTIVE * V_ACTIVE);

        // Mid-frame adjust: current frame unchanged, next frame shifted
        run_until_v(5, 2 * FRAME_CLKS);
        ha_v = -8; va_v = 3;
        wait_ev(1, 400, n);
        chk("hs_keep_h", hcount, 52);
        wait_ev(0, 2 * FRAME_CLKS, n);
        wait_ev(1, 400, n);
        chk("hs_m8_h", hcount, 44);
        wait_ev(3, 2 * FRAME_CLKS, n);
        chk("vs_p3_v", vcount, 16);
        chk("vs_p3_h", hcount, 44);
        wait_ev(4, 2 * FRAME_CLKS, n);
        chk("vs_p3_fall_v", vcount, 18);

        // Both clamps: +7 pins HSync at the line end, -4 pins VSync at V_ACTIVE
        ha_v = 7; va_v = -4;
        wait_ev(0, 2 * FRAME_CLKS, n);
        wait_ev(1, 400, n);
        chk("hs_clamp_h", hcount, 56);
        wait_ev(2, 400, n);
        chk("hs_nowrap_h", hcount, 0);
        wait_ev(3, 2 * FRAME_CLKS, n);
        chk("vs_clamp_v", vcount, 12);

        // One-clock reset mid-frame; shadows follow the adjust inputs during reset
        run_until_v(8, 2 * FRAME_CLKS);
        ha_v = -8; va_v = 2; rst_v = 1;
        cyc();
        chk("mrst_hcount", hcount, H_TOTAL - 1);
        chk("mrst_flags", {ce_pix, HBlank, VBlank, HSync, VSync, frame_start, line_start}, 7'b0110000);
        rst_v = 0;
        wait_ev(0, 20, n);
        chk("mrst_fs_clk", n, CE_DIV);
        wait_ev(1, 400, n);
        chk("mrst_hs_h", hcount, 44);
        wait_ev(3, 2 * FRAME_CLKS, n);
        chk("mrst_vs_v", vcount, 15);

        // Random adjust churn every line; scoreboard checks each clock
        for (int i = 0; i < 2 * FRAME_CLKS; i++) begin
            if (line_start) begin
                ha_v = 4'($urandom_range(15));
                va_v = 3'($urandom_range(7));
            end
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
